// File: rtl/register_file.sv
// RV32I integer register file: 32x32, two async read ports, one sync write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_en;

  assign wr_en = reg_write && (rd != '0);

  // entry 0 is cleared by reset and never written, so it always reads 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rd] <= write_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    read_data1 = regs[rs1];
    read_data2 = regs[rs2];
    if (wr_en && (rs1 == rd)) read_data1 = write_data;
    if (wr_en && (rs2 == rd)) read_data2 = write_data;
    if (rs1 == '0) read_data1 = '0;
    if (rs2 == '0) read_data2 = '0;
  end
`else
  always_comb begin
    read_data1 = regs[rs1];
    read_data2 = regs[rs2];
    if (rs1 == '0) read_data1 = '0;
    if (rs2 == '0) read_data2 = '0;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table plus reset, x0 and
// same-cycle read-of-rd sequences.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        reg_write;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int checks = 0;
  int failures = 0;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_write (reg_write),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .write_data(write_data),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // expectations are sampled before the edge that commits each write
    vecs[0]  = '{1'b1, 5'd5,  32'd10,         5'd0,  5'd0,  32'd0,          32'd0};
    vecs[1]  = '{1'b1, 5'd10, 32'd20,         5'd5,  5'd0,  32'd10,         32'd0};
    vecs[2]  = '{1'b1, 5'd15, 32'd30,         5'd5,  5'd10, 32'd10,         32'd20};
    vecs[3]  = '{1'b0, 5'd0,  32'd0,          5'd15, 5'd0,  32'd30,         32'd0};
    vecs[4]  = '{1'b1, 5'd0,  32'hDEADBEEF,   5'd0,  5'd15, 32'd0,          32'd30};
    vecs[5]  = '{1'b0, 5'd0,  32'd0,          5'd0,  5'd5,  32'd0,          32'd10};
    vecs[6]  = '{1'b1, 5'd7,  32'h1234_5678,  5'd10, 5'd15, 32'd20,         32'd30};
    vecs[7]  = '{1'b1, 5'd7,  32'hFFFF_FFFF,  5'd5,  5'd15, 32'd10,         32'd30};
    vecs[8]  = '{1'b0, 5'd7,  32'hAAAA_5555,  5'd7,  5'd7,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vecs[9]  = '{1'b0, 5'd7,  32'h0,          5'd7,  5'd0,  32'hFFFF_FFFF,  32'd0};
    vecs[10] = '{1'b1, 5'd31, 32'h8000_0001,  5'd1,  5'd2,  32'd0,          32'd0};
    vecs[11] = '{1'b1, 5'd1,  32'd11,         5'd31, 5'd7,  32'h8000_0001,  32'hFFFF_FFFF};
    vecs[12] = '{1'b0, 5'd0,  32'd0,          5'd1,  5'd31, 32'd11,         32'h8000_0001};

    rst = 1'b1;
    reg_write = 1'b0;
    rs1 = '0;
    rs2 = '0;
    rd = '0;
    write_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      chk("in_reset_rd1", read_data1, 32'd0);
      chk("in_reset_rd2", read_data2, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      chk("post_reset_rd1", read_data1, 32'd0);
      chk("post_reset_rd2", read_data2, 32'd0);
    end

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      reg_write  = vecs[i].we;
      rd         = vecs[i].rd;
      write_data = vecs[i].wd;
      rs1        = vecs[i].rs1;
      rs2        = vecs[i].rs2;
      #1;
      chk($sformatf("vec%0d_rd1", i), read_data1, vecs[i].exp1);
      chk($sformatf("vec%0d_rd2", i), read_data2, vecs[i].exp2);
    end

    // same-cycle read of the register being written
    @(negedge clk);
    reg_write = 1'b1; rd = 5'd3; write_data = 32'd1;
    rs1 = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    reg_write = 1'b1; rd = 5'd3; write_data = 32'd2;
    rs1 = 5'd3; rs2 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_rd1", read_data1, 32'd2);
    chk("same_cycle_rd2", read_data2, 32'd2);
`else
    chk("same_cycle_rd1", read_data1, 32'd1);
    chk("same_cycle_rd2", read_data2, 32'd1);
`endif
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    #1;
    chk("after_commit_rd1", read_data1, 32'd2);

    // x0 is never bypassed
    @(negedge clk);
    reg_write = 1'b1; rd = 5'd0; write_data = 32'hDEADBEEF;
    rs1 = 5'd0; rs2 = 5'd5;
    #1;
    chk("x0_same_cycle", read_data1, 32'd0);
    chk("x5_before_rst", read_data2, 32'd10);

    // async reset between edges, write held across an edge in reset
    @(negedge clk);
    reg_write = 1'b0; rs1 = 5'd5; rs2 = 5'd7;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rd1", read_data1, 32'd0);
    chk("async_rst_rd2", read_data2, 32'd0);
    reg_write = 1'b1; rd = 5'd5; write_data = 32'd99;
    @(posedge clk);
    #1;
    chk("write_in_rst", read_data1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    reg_write = 1'b1; rd = 5'd5; write_data = 32'd77;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    #1;
    chk("first_write_after_rst", read_data1, 32'd77);
    chk("x7_still_clear", read_data2, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
